mem_moc_unit: RTL and testbench
===============================

# mem_moc_unit

Word/byte-addressable data memory that answers the control unit's memory-operation handshake. It sits directly downstream of the control unit's MAR/MDR datapath: it accepts MOV/RW/typeData plus address and write data, inserts programmable wait states, performs the access, and returns MOC with read data for the MDR. It is the memory the control unit's fetch and load/store states stall on.

## Interface
- ADDR_W, 8: address bits used; memory depth is 2^ADDR_W bytes.
- WAIT_CYC, 2: wait states between request acceptance and access, range 0..15.

- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- MOV  in  1  memory operation valid from the control unit.
- RW  in  1  1 = read, 0 = write.
- typeData  in  1  1 = word (32-bit), 0 = byte.
- addr  in  32  byte address from MAR; only addr[ADDR_W-1:0] is used.
- dataIn  in  32  write data from MDR.
- dataOut  out  32  read data to MDR.
- moc  out  1  memory operation complete.
- busy  out  1  high in WAIT and DONE.

## Operation
- Storage: 2^ADDR_W x 8-bit array. Contents are not cleared by CLR.
- Big-endian: word at address A occupies bytes A (bits 31:24), A+1, A+2, A+3 (bits 7:0).
- Word accesses force addr[1:0] to 0. Words never wrap past the top of memory.
- Byte read returns {24'b0, mem[A]}. Byte write stores dataIn[7:0] only; the other bytes are untouched.
- Upper address bits above ADDR_W are ignored, so addresses alias modulo 2^ADDR_W.
- FSM states:
  - IDLE: on MOV=1, capture addr, RW, typeData and dataIn, load cnt=WAIT_CYC, go to WAIT.
  - WAIT: if cnt==0, perform the access and go to DONE; otherwise decrement cnt. Captured operands are used, so input changes during WAIT are ignored.
  - DONE: moc=1. Leave to IDLE on the first edge where MOV=0.
- Write commits on the WAIT->DONE edge. A read loads dataOut on the same edge.
- dataOut holds the last read value until the next read; writes do not change it.
- MOV dropped during WAIT: the operation still completes. DONE is entered, moc is high for exactly one cycle, then the FSM returns to IDLE.
- MOV held high after a DONE->IDLE exit cannot occur, because the exit requires MOV=0. A new request therefore always needs MOV to drop and rise again.
- moc, busy and dataOut are registered outputs.

## Timing
- Reset values: moc=0, busy=0, dataOut=32'h0, state=IDLE, cnt=0.
- CLR has priority over all activity. CLR during WAIT aborts the operation with no write performed. CLR during DONE drops moc on the next edge.
- Latency: MOV=1 sampled in IDLE at edge k; moc=1 after edge k+1+WAIT_CYC. With WAIT_CYC=0, moc=1 after edge k+1.
- moc falls on the edge after MOV is sampled low in DONE.
- Back-to-back: the minimum request-to-request spacing is WAIT_CYC+3 cycles.

## Test plan
- Reset: hold CLR=1 for 2 cycles with MOV=1 -> moc=0, busy=0, dataOut=0. No write occurs.
- Word write then word read, WAIT_CYC=2:
  - Write 0xE7D12000 to addr 0x10; MOV rises at edge k -> moc=1 after edge k+3.
  - Read addr 0x12 (aligned to 0x10) -> dataOut=0xE7D12000.
- Byte access to the same word:
  - Read byte addr 0x11 -> dataOut=0x000000D1.
  - Write byte 0xAB to 0x13, then read word 0x10 -> 0xE7D120AB.
- Aliasing: write word 0x11223344 at addr 0x00000104 with ADDR_W=8 -> read of addr 0x04 returns 0x11223344.
- Handshake edges:
  - Drop MOV during WAIT -> moc high for exactly 1 cycle, then IDLE.
  - Hold MOV in DONE for 4 cycles -> moc stays high for 4 cycles and falls 1 edge after MOV=0.
- Reset mid-op: assert CLR in WAIT during a write of 0xFFFFFFFF to 0x20 -> a later read of 0x20 returns the prior value, and moc is never asserted.

Source files
------------

// File: rtl/mem_moc_unit.sv
// mem_moc_unit
//   Byte/word addressable data memory that answers the control unit's
//   MOV/MOC handshake. A request is captured in IDLE. The unit then waits
//   WAIT_CYC cycles in WAIT, performs the access, and raises moc in DONE
//   until MOV drops.
//
// Ports
//   CLK       clock, rising edge
//   CLR       synchronous active-high reset
//   MOV       memory operation valid
//   RW        1 = read, 0 = write
//   typeData  1 = 32-bit word, 0 = byte
//   addr      byte address; only addr[ADDR_W-1:0] is used
//   dataIn    write data (byte writes use dataIn[7:0])
//   dataOut   registered read data; holds until the next read
//   moc       registered memory-operation-complete
//   busy      registered, high while in WAIT or DONE
module mem_moc_unit #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic        typeData,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        moc,
  output logic        busy
);

  localparam int          WORDS     = 1 << (ADDR_W - 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic                rw_reg;
  logic                word_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         data_reg;

  // Access fires on the WAIT->DONE edge; CLR suppresses it so an aborted
  // write never reaches the array.
  logic access_go;
  assign access_go = (state_reg == S_WAIT) && (cnt_reg == 4'd0) && !CLR;

  // Upper address bits alias away by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W];

  // Big-endian word view of the addressed row: lane 0 is bits 31:24.
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  // Memory is split into four byte lanes so a word access touches one row
  // in every lane while a byte access touches only its own lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] bank [WORDS];
      logic       wr_en;
      logic [7:0] wr_byte;

      assign wr_en   = access_go && !rw_reg &&
                       (word_reg || (addr_reg[1:0] == 2'(gi)));
      assign wr_byte = word_reg ? data_reg[31-8*gi -: 8] : data_reg[7:0];
      assign rd_word[31-8*gi -: 8] = bank[addr_reg[ADDR_W-1:2]];

      always_ff @(posedge CLK) begin
        if (wr_en) begin
          bank[addr_reg[ADDR_W-1:2]] <= wr_byte;
        end
      end
    end
  endgenerate

  // Lane 3 needs no shift, lane 0 shifts down by 24.
  logic [31:0] rd_shift;
  assign rd_shift = rd_word >> {~addr_reg[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      rw_reg    <= 1'b0;
      word_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= 32'h0;
      dataOut   <= 32'h0;
      moc       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (MOV) begin
            rw_reg    <= RW;
            word_reg  <= typeData;
            // Word accesses are forced to a 4-byte boundary at capture.
            addr_reg  <= typeData ? {addr[ADDR_W-1:2], 2'b00} : addr[ADDR_W-1:0];
            data_reg  <= dataIn;
            cnt_reg   <= WAIT_INIT;
            state_reg <= S_WAIT;
            busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (rw_reg) begin
              dataOut <= word_reg ? rd_word : {24'h0, rd_byte};
            end
            state_reg <= S_DONE;
            moc       <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_DONE: begin
          if (!MOV) begin
            state_reg <= S_IDLE;
            moc       <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          moc       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_moc_unit.sv
module tb_mem_moc_unit;

  localparam int ADDR_W   = 8;
  localparam int WAIT_CYC = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic        typeData = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] dataIn = 32'h0;
  logic [31:0] dataOut;
  logic        moc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] exp_q [$];

  mem_moc_unit #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .CLK(CLK), .CLR(CLR), .MOV(MOV), .RW(RW), .typeData(typeData),
    .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .moc(moc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: expected dataOut pushed at request time.
  task automatic model_op(input bit rd, input bit wd, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] ai;
    ai = a[7:0];
    if (wd) ai[1:0] = 2'b00;
    if (rd) begin
      if (wd) last_rd = {model_mem[ai], model_mem[ai+8'd1], model_mem[ai+8'd2], model_mem[ai+8'd3]};
      else    last_rd = {24'h0, model_mem[ai]};
    end else begin
      if (wd) begin
        model_mem[ai]       = d[31:24];
        model_mem[ai+8'd1]  = d[23:16];
        model_mem[ai+8'd2]  = d[15:8];
        model_mem[ai+8'd3]  = d[7:0];
      end else begin
        model_mem[ai] = d[7:0];
      end
    end
    exp_q.push_back(last_rd);
  endtask

  // One handshake. hold = cycles moc stays high (MOV held); drop_early
  // lowers MOV and scrambles operands right after acceptance.
  task automatic op(input string tag, input bit rd, input bit wd, input logic [31:0] a,
                    input logic [31:0] d, input int hold, input bit drop_early);
    int cyc;
    logic [31:0] exp;
    model_op(rd, wd, a, d);
    MOV = 1'b1; RW = rd; typeData = wd; addr = a; dataIn = d;
    tick();
    check({tag, "_busy_accept"}, {31'h0, busy}, 32'h1);
    if (drop_early) begin
      MOV = 1'b0; RW = ~rd; typeData = ~wd;
      addr = $urandom; dataIn = $urandom;
    end
    cyc = 0;
    while (!moc && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, WAIT_CYC + 1);
    exp = exp_q.pop_front();
    check({tag, "_data"}, dataOut, exp);
    for (int i = 1; i < hold; i++) begin
      tick();
      check({tag, "_moc_hold"}, {31'h0, moc}, 32'h1);
    end
    MOV = 1'b0;
    tick();
    check({tag, "_moc_fall"}, {31'h0, moc}, 32'h0);
    check({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    // Reset with MOV asserted: nothing must start.
    CLR = 1'b1; MOV = 1'b1; RW = 1'b0; typeData = 1'b1;
    addr = 32'h30; dataIn = 32'hDEADBEEF;
    tick(); tick();
    check("rst_moc", {31'h0, moc}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_dout", dataOut, 32'h0);
    CLR = 1'b0; MOV = 1'b0;
    tick();
    check("rst_idle_busy", {31'h0, busy}, 32'h0);

    op("wr_word", 1'b0, 1'b1, 32'h10, 32'hE7D12000, 1, 1'b0);
    check("wr_keeps_dout", dataOut, 32'h0);
    op("rd_word_align", 1'b1, 1'b1, 32'h12, 32'h0, 1, 1'b0);
    op("rd_byte", 1'b1, 1'b0, 32'h11, 32'h0, 1, 1'b0);
    op("wr_byte", 1'b0, 1'b0, 32'h13, 32'hFFFFFFAB, 1, 1'b0);
    op("rd_word_mod", 1'b1, 1'b1, 32'h10, 32'h0, 1, 1'b0);
    op("rd_byte3", 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b0);
    op("wr_alias", 1'b0, 1'b1, 32'h00000104, 32'h11223344, 1, 1'b0);
    op("rd_alias", 1'b1, 1'b1, 32'h04, 32'h0, 1, 1'b0);
    op("wr_drop", 1'b0, 1'b1, 32'h20, 32'h5A5A5A5A, 1, 1'b1);
    op("rd_drop", 1'b1, 1'b1, 32'h20, 32'h0, 1, 1'b1);
    op("rd_hold4", 1'b1, 1'b0, 32'h22, 32'h0, 4, 1'b0);

    // Reset in WAIT during a write: aborted, no moc, dataOut cleared.
    MOV = 1'b1; RW = 1'b0; typeData = 1'b1; addr = 32'h20; dataIn = 32'hFFFFFFFF;
    tick();
    check("abort_busy", {31'h0, busy}, 32'h1);
    tick();
    CLR = 1'b1;
    tick();
    check("abort_moc", {31'h0, moc}, 32'h0);
    check("abort_busy_clr", {31'h0, busy}, 32'h0);
    check("abort_dout", dataOut, 32'h0);
    last_rd = 32'h0;
    CLR = 1'b0; MOV = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_moc", {31'h0, moc}, 32'h0);
    end
    op("rd_after_abort", 1'b1, 1'b1, 32'h20, 32'h0, 1, 1'b0);

    // Reset with a write request pending must not touch memory.
    CLR = 1'b1; MOV = 1'b1; RW = 1'b0; typeData = 1'b1;
    addr = 32'h10; dataIn = 32'hDEADBEEF;
    tick(); tick();
    check("rst2_moc", {31'h0, moc}, 32'h0);
    last_rd = 32'h0;
    CLR = 1'b0; MOV = 1'b0;
    tick();
    op("rd_after_rst2", 1'b1, 1'b1, 32'h10, 32'h0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
